alu_sequencer: RTL and testbench
================================

# alu_sequencer

Execute-stage sequencer for the RV32I core: the initiator side of the ALU operand/result interface (drives `a`, `b`, `sel`; consumes `Y`, `zero`). It accepts one decoded instruction per valid/ready handshake, maps it to an ALU operation, holds operands stable for one execute cycle, captures the ALU result and zero flag, and returns a registered result plus branch decision through a second valid/ready handshake. The `alu` itself is external and purely combinational.

## Interface
Parameters:
- none; datapath fixed at 32 bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_valid`  in  1  instruction fields valid.
- `in_ready`  out  1  sequencer can accept (high only in IDLE).
- `op_class`  in  3  0=OP, 1=OP_IMM, 2=BRANCH, 3=ADDR (load/store/jalr), 4=AUIPC, 5=LUI; 6,7 illegal.
- `funct3`  in  3  instruction funct3.
- `funct7_5`  in  1  instruction bit 30.
- `rs1_val`, `rs2_val`, `imm`, `pc`  in  32 each  operands.
- `alu_a`, `alu_b`  out  32  registered ALU operands.
- `alu_sel`  out  4  registered ALU select.
- `alu_y`  in  32  ALU result.
- `alu_zero`  in  1  ALU zero flag.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts result.
- `result`  out  32  captured ALU result.
- `branch_taken`  out  1  branch decision (0 for non-branch).
- `illegal`  out  1  unsupported op_class/funct3 combination.

## Operation
- ALU select: sel[3:1] = ALU function, sel[0] = variant: 0000 add, 0001 sub, 001x sll, 010x slt, 011x sltu, 100x xor, 1010 srl, 1011 sra, 110x or, 111x and.
- Operand/select mapping at accept:
  - OP: a=rs1, b=rs2, sel={funct3, funct7_5}.
  - OP_IMM: a=rs1, b=imm, sel={funct3, funct3==101 ? funct7_5 : 0}; no SUBI.
  - BRANCH, funct3 → sel / taken:
    - 000 BEQ: 0001 / zero.
    - 001 BNE: 0001 / !zero.
    - 100 BLT: 0100 / Y[0].
    - 101 BGE: 0100 / !Y[0].
    - 110 BLTU: 0110 / Y[0].
    - 111 BGEU: 0110 / !Y[0].
    - a=rs1, b=rs2.
  - ADDR: a=rs1, b=imm, sel=0000.
  - AUIPC: a=pc, b=imm, sel=0000.
  - LUI: a=0, b=imm, sel=0000.
- Illegal cases:
  - Which: BRANCH funct3 010/011; op_class 6/7.
  - Accept normally; operands and sel forced to 0; in RESP, result=0, branch_taken=0, illegal=1.
- FSM: IDLE → EXEC → RESP → IDLE.
  - IDLE: in_ready=1. On in_valid, load alu_a/alu_b/alu_sel and the latched branch kind; go to EXEC.
  - EXEC: ALU settles on the registered operands; at the clock edge capture result=alu_y and compute branch_taken; go to RESP.
  - RESP: out_valid=1, outputs held stable. On out_ready, go to IDLE.
- alu_a/alu_b/alu_sel hold their last values in RESP and IDLE; they change only at accept.

## Timing
- Reset (rst_n low at an edge), regardless of state:
  - State=IDLE.
  - in_ready=1 on the following cycle.
  - out_valid=0, result=0, branch_taken=0, illegal=0, alu_a=0, alu_b=0, alu_sel=0.
  - A transaction in progress is discarded; no output handshake occurs for it.
- Handshakes:
  - Accept when in_valid && in_ready at edge k.
  - Edge k+1 = EXEC capture.
  - out_valid high from cycle after k+1.
  - Transfer when out_valid && out_ready at an edge.
- Latency: out_valid 2 cycles after accept. Minimum issue interval 3 cycles (out_ready held high).
- Stall: result, branch_taken and illegal must not change while out_valid=1 && !out_ready.
- Input ignore rule: in_valid is ignored outside IDLE; in_ready is 0 in EXEC and RESP.
- No in_ready/out_ready combinational path: in_ready is a pure function of state.
- Arithmetic: all 32-bit, wrap-around, carry discarded (0xFFFFFFFF+1 → 0, zero per ALU).

## Test plan
- Reset, then 3 ops:
  - Stimulus: reset for 2 cycles, then OP add rs1=3, rs2=6; then OP sub 3,6; then OP sub 3,3.
  - Required: result 9, then 0xFFFFFFFD, then 0; out_valid exactly 2 cycles after each accept.
- Branches:
  - BEQ 5,5 → taken=1.
  - BNE 5,5 → taken=0.
  - BLT 0xFFFFFFFF,1 → taken=1.
  - BLTU 0xFFFFFFFF,1 → taken=0.
  - BGEU 0xFFFFFFFF,1 → taken=1.
- Shifts:
  - OP_IMM funct3=101, f7_5=0, rs1=0x80000000, imm=4 → 0x08000000.
  - Same with f7_5=1 → 0xF8000000.
  - OP_IMM funct3=000, f7_5=1 → add, not sub.
- Back-pressure:
  - Stimulus: out_ready=0 for 5 cycles in RESP while in_valid=1 with new fields.
  - Required: result stable; in_ready=0; new fields not taken; accept only after out_ready pulse and return to IDLE.
- Illegal and address ops:
  - BRANCH funct3=010 → illegal=1, result=0, taken=0.
  - AUIPC pc=0x1000, imm=0x2000 → 0x3000.
  - LUI imm=0xABCDE000 → 0xABCDE000.
- Reset mid-operation:
  - Stimulus: rst_n low in EXEC.
  - Required: out_valid stays 0, all outputs 0 next cycle, in_ready=1 after release; next transaction completes normally.

Source files
------------

// File: rtl/alu_sequencer.sv
// alu_sequencer: RV32I execute-stage sequencer driving an external combinational ALU
module alu_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  op_class,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic [31:0] rs1_val,
  input  logic [31:0] rs2_val,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [31:0] alu_y,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        branch_taken,
  output logic        illegal
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, nstate;
  logic [31:0] na, nb;
  logic [3:0] ns;
  logic nbr, nill, br, ill;
  logic [2:0] bf3;
  assign in_ready = state == IDLE;
  assign out_valid = state == RESP;
  // state register
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  // next-state: accept in IDLE, one execute cycle, hold response until taken
  always_comb begin
    nstate = state;
    case (state)
      IDLE: nstate = in_valid ? EXEC : IDLE;
      EXEC: nstate = RESP;
      RESP: nstate = out_ready ? IDLE : RESP;
      default: nstate = IDLE;
    endcase
  end
  // decode instruction fields into ALU operands/select; illegal forms zero everything
  always_comb begin
    na = rs1_val;
    nb = imm;
    ns = 4'b0000;
    nbr = 1'b0;
    nill = 1'b0;
    case (op_class)
      3'd0: begin nb = rs2_val; ns = {funct3, funct7_5}; end
      3'd1: ns = {funct3, funct3 == 3'b101 ? funct7_5 : 1'b0};
      3'd2: begin
        nb = rs2_val;
        nbr = 1'b1;
        ns = funct3[2] ? {2'b01, funct3[1], 1'b0} : 4'b0001;
        nill = funct3[2:1] == 2'b01;
      end
      3'd4: na = pc;
      3'd5: na = '0;
      3'd6, 3'd7: nill = 1'b1;
      default: ;
    endcase
    if (nill) begin
      na = '0;
      nb = '0;
      ns = '0;
      nbr = 1'b0;
    end
  end
  // operands latch at accept; results capture at the end of the execute cycle
  always_ff @(posedge clk)
    if (!rst_n) begin
      alu_a <= '0;
      alu_b <= '0;
      alu_sel <= '0;
      br <= 1'b0;
      bf3 <= '0;
      ill <= 1'b0;
      result <= '0;
      branch_taken <= 1'b0;
      illegal <= 1'b0;
    end else begin
      if (state == IDLE && in_valid) begin
        alu_a <= na;
        alu_b <= nb;
        alu_sel <= ns;
        br <= nbr;
        bf3 <= funct3;
        ill <= nill;
      end
      if (state == EXEC) begin
        result <= ill ? '0 : alu_y;
        branch_taken <= br & ((bf3[2] ? alu_y[0] : alu_zero) ^ bf3[0]);
        illegal <= ill;
      end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed self-checking bench for alu_sequencer with a behavioural ALU
module tb_alu_sequencer;
  logic clk = 0, rst_n = 0, in_valid = 0, in_ready, funct7_5 = 0;
  logic [2:0] op_class = 0, funct3 = 0;
  logic [31:0] rs1_val = 0, rs2_val = 0, imm = 0, pc = 0;
  logic [31:0] alu_a, alu_b, alu_y, result;
  logic [3:0] alu_sel;
  logic alu_zero, out_valid, out_ready = 0, branch_taken, illegal;
  int n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op_class(op_class), .funct3(funct3), .funct7_5(funct7_5),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm), .pc(pc),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y), .alu_zero(alu_zero),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .branch_taken(branch_taken), .illegal(illegal)
  );

  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s);
    case (s[3:1])
      3'd0: return s[0] ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return {31'b0, $signed(a) < $signed(b)};
      3'd3: return {31'b0, a < b};
      3'd4: return a ^ b;
      3'd5: return s[0] ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  assign alu_y = alu(alu_a, alu_b, alu_sel);
  assign alu_zero = alu_y == 32'd0;

  task automatic issue(input logic [2:0] oc, input logic [2:0] f3, input logic f75,
                       input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] im,
                       input logic [31:0] p, output logic [31:0] res, output logic tk,
                       output logic il, output int lat);
    int w;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 20) begin @(negedge clk); w++; end
    op_class = oc; funct3 = f3; funct7_5 = f75;
    rs1_val = r1; rs2_val = r2; imm = im; pc = p; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    lat = 1;
    while (!out_valid && lat < 10) begin @(posedge clk); #1; lat++; end
    if (!out_valid) lat = 99;
    res = result; tk = branch_taken; il = illegal;
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    n_cmp++; if ({out_valid, result, branch_taken, illegal} !== 35'd0) begin n_bad++;
      $display("FAIL reset_outputs got ov=%b res=%h tk=%b il=%b want all 0", out_valid, result, branch_taken, illegal); end
    n_cmp++; if ({alu_a, alu_b, alu_sel} !== 68'd0) begin n_bad++;
      $display("FAIL reset_alu got a=%h b=%h sel=%h want 0", alu_a, alu_b, alu_sel); end
    rst_n = 1;
  endtask

  task automatic test_arith;
    logic [31:0] r; logic t, i; int l;
    issue(3'd0, 3'd0, 1'b0, 32'd3, 32'd6, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'd9) begin n_bad++; $display("FAIL add got %h want 00000009", r); end
    n_cmp++; if (l !== 2) begin n_bad++; $display("FAIL add_latency got %0d want 2", l); end
    issue(3'd0, 3'd0, 1'b1, 32'd3, 32'd6, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'hFFFFFFFD) begin n_bad++; $display("FAIL sub got %h want fffffffd", r); end
    n_cmp++; if (l !== 2) begin n_bad++; $display("FAIL sub_latency got %0d want 2", l); end
    issue(3'd0, 3'd0, 1'b1, 32'd3, 32'd3, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'd0 || t !== 1'b0 || i !== 1'b0) begin n_bad++;
      $display("FAIL sub_zero got res=%h tk=%b il=%b want 0/0/0", r, t, i); end
  endtask

  task automatic test_branch;
    logic [31:0] r; logic t, i; int l;
    issue(3'd2, 3'b000, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL beq got %b want 1", t); end
    issue(3'd2, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL bne got %b want 0", t); end
    issue(3'd2, 3'b100, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b1) begin n_bad++; $display("FAIL blt got %b want 1", t); end
    issue(3'd2, 3'b101, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL bge got %b want 0", t); end
    issue(3'd2, 3'b110, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b0) begin n_bad++; $display("FAIL bltu got %b want 0", t); end
    issue(3'd2, 3'b111, 1'b0, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (t !== 1'b1 || i !== 1'b0) begin n_bad++; $display("FAIL bgeu got tk=%b il=%b want 1/0", t, i); end
  endtask

  task automatic test_shift;
    logic [31:0] r; logic t, i; int l;
    issue(3'd1, 3'b101, 1'b0, 32'h80000000, 32'd7, 32'd4, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'h08000000) begin n_bad++; $display("FAIL srli got %h want 08000000", r); end
    issue(3'd1, 3'b101, 1'b1, 32'h80000000, 32'd7, 32'd4, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'hF8000000) begin n_bad++; $display("FAIL srai got %h want f8000000", r); end
    issue(3'd1, 3'b000, 1'b1, 32'd10, 32'd7, 32'd3, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'd13) begin n_bad++; $display("FAIL addi_f75 got %h want 0000000d", r); end
    issue(3'd3, 3'b010, 1'b1, 32'hFFFFFFFF, 32'd7, 32'd1, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL addr_wrap got %h want 00000000", r); end
  endtask

  task automatic test_back_to_back;
    int bad_res = 0, bad_rdy = 0, w = 0;
    @(negedge clk);
    op_class = 3'd0; funct3 = 3'd0; funct7_5 = 0; rs1_val = 32'd10; rs2_val = 32'd20; in_valid = 1;
    @(posedge clk); #1;
    rs1_val = 32'd100; rs2_val = 32'd1; funct7_5 = 1;
    while (!out_valid && w < 10) begin @(posedge clk); #1; w++; end
    repeat (5) begin
      if (result !== 32'd30) bad_res++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1) bad_rdy++;
      @(posedge clk); #1;
    end
    n_cmp++; if (bad_res !== 0) begin n_bad++; $display("FAIL stall_result got %0d unstable cycles (res=%h) want 0 (30)", bad_res, result); end
    n_cmp++; if (bad_rdy !== 0) begin n_bad++; $display("FAIL stall_handshake got %0d bad cycles want 0", bad_rdy); end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL stall_release in_ready got %b want 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 0;
    w = 0;
    while (!out_valid && w < 10) begin @(posedge clk); #1; w++; end
    n_cmp++; if (result !== 32'd99 || w !== 1) begin n_bad++; $display("FAIL stall_next got res=%h wait=%0d want 00000063/1", result, w); end
    out_ready = 1;
    @(posedge clk); #1;
    out_ready = 0;
  endtask

  task automatic test_illegal_addr;
    logic [31:0] r; logic t, i; int l;
    issue(3'd2, 3'b010, 1'b0, 32'd5, 32'd5, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (i !== 1'b1 || r !== 32'd0 || t !== 1'b0) begin n_bad++;
      $display("FAIL illegal_br got il=%b res=%h tk=%b want 1/0/0", i, r, t); end
    issue(3'd7, 3'b000, 1'b0, 32'd5, 32'd6, 32'd7, 32'd8, r, t, i, l);
    n_cmp++; if (i !== 1'b1 || r !== 32'd0 || alu_a !== 32'd0) begin n_bad++;
      $display("FAIL illegal_class got il=%b res=%h a=%h want 1/0/0", i, r, alu_a); end
    issue(3'd4, 3'b000, 1'b0, 32'd5, 32'd0, 32'h2000, 32'h1000, r, t, i, l);
    n_cmp++; if (r !== 32'h3000 || i !== 1'b0) begin n_bad++; $display("FAIL auipc got res=%h il=%b want 00003000/0", r, i); end
    issue(3'd5, 3'b000, 1'b0, 32'd5, 32'd0, 32'hABCDE000, 32'h1000, r, t, i, l);
    n_cmp++; if (r !== 32'hABCDE000) begin n_bad++; $display("FAIL lui got %h want abcde000", r); end
  endtask

  task automatic test_reset_mid;
    logic [31:0] r; logic t, i; int l, seen = 0;
    @(negedge clk);
    op_class = 3'd0; funct3 = 3'd0; funct7_5 = 0; rs1_val = 32'd7; rs2_val = 32'd8; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    rst_n = 0;
    @(posedge clk); #1;
    rst_n = 1;
    n_cmp++; if ({out_valid, result, branch_taken, illegal, alu_a, alu_b, alu_sel} !== 103'd0) begin n_bad++;
      $display("FAIL midreset_outputs got ov=%b res=%h a=%h b=%h sel=%h want 0", out_valid, result, alu_a, alu_b, alu_sel); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL midreset_in_ready got %b want 1", in_ready); end
    repeat (4) begin
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    n_cmp++; if (seen !== 0) begin n_bad++; $display("FAIL midreset_no_resp got %0d valid cycles want 0", seen); end
    issue(3'd0, 3'b100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'd0, 32'd0, r, t, i, l);
    n_cmp++; if (r !== 32'h0FF00FF0 || l !== 2) begin n_bad++; $display("FAIL midreset_next got res=%h lat=%0d want 0ff00ff0/2", r, l); end
  endtask

  initial begin
    test_reset;
    test_arith;
    test_branch;
    test_shift;
    test_back_to_back;
    test_illegal_addr;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
